// File: rtl/gte2_refclk_pkg.sv
// Shared types for the GTE2 reference-clock sequencer: state encoding,
// fault counter width and the per-state output decode.
package gte2_refclk_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_READY   = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam int unsigned FAULT_CNT_W = 8;

  typedef struct packed {
    logic ceb;
    logic gt_reset;
    logic refclk_ready;
    logic fault;
  } ctrl_out_t;

  // The buffer stays enabled and the GT stays in reset everywhere except the two ends.
  function automatic ctrl_out_t decode_outputs(state_t s);
    ctrl_out_t o;
    o = '{ceb: 1'b0, gt_reset: 1'b1, refclk_ready: 1'b0, fault: 1'b0};
    case (s)
      ST_OFF:   o.ceb = 1'b1;
      ST_READY: begin
        o.gt_reset     = 1'b0;
        o.refclk_ready = 1'b1;
      end
      ST_FAULT: o.fault = 1'b1;
      default:  ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/gte2_refclk_sync.sv
// Brings the refclk-domain toggle into aclk and turns each transition of it,
// in either direction, into a single-cycle edge pulse.
module gte2_refclk_sync (
  input  logic aclk,
  input  logic aresetn,
  input  logic refclk_tgl,
  output logic edge_pulse
);

  logic sync1;
  logic sync2;
  logic dly;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
    end else begin
      sync1 <= refclk_tgl;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign edge_pulse = sync2 ^ dly;

endmodule

// File: rtl/gte2_refclk_ctrl.sv
// Reference-clock bring-up sequencer: enables the buffer, waits, measures the
// clock frequency, releases the transceiver reset and watches for clock loss.
//
//   state   | meaning
//   OFF     | buffer disabled, waiting for enable
//   SETTLE  | buffer enabled, waiting for the clock to settle
//   MEASURE | counting refclk edges over one window
//   READY   | clock verified, GT out of reset, loss monitor running
//   FAULT   | bad frequency or lost clock, waiting before a retry
module gte2_refclk_ctrl
  import gte2_refclk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned MIN_EDGES     = 200,
  parameter int unsigned MAX_EDGES     = 300,
  parameter int unsigned LOSS_CYCLES   = 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic                   refclk_tgl,
  output logic                   ceb,
  output logic                   gt_reset,
  output logic                   refclk_ready,
  output logic                   fault,
  output logic [CNT_W-1:0]       freq_count,
  output logic [FAULT_CNT_W-1:0] fault_cnt,
  output logic [2:0]             state
);

  if (CNT_W == 0 || CNT_W > 31 ||
      SETTLE_CYCLES == 0 || WINDOW_CYCLES == 0 || MIN_EDGES == 0 ||
      MAX_EDGES == 0 || LOSS_CYCLES == 0 || MIN_EDGES > MAX_EDGES ||
      (SETTLE_CYCLES >> CNT_W) != 0 || (WINDOW_CYCLES >> CNT_W) != 0 ||
      (MIN_EDGES >> CNT_W) != 0 || (MAX_EDGES >> CNT_W) != 0 ||
      (LOSS_CYCLES >> CNT_W) != 0) begin : g_param_check
    $error("gte2_refclk_ctrl: invalid parameter set");
  end

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_LOAD = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_C       = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0] MAX_C       = CNT_W'(MAX_EDGES);
  localparam logic [CNT_W-1:0] LOSS_C      = CNT_W'(LOSS_CYCLES);
  localparam logic [FAULT_CNT_W-1:0] FCNT_MAX = '1;
  localparam logic [FAULT_CNT_W-1:0] FCNT_ONE = FAULT_CNT_W'(1);

  state_t                 state_q;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       timer_q;
  logic [CNT_W-1:0]       timer_nxt;
  logic [CNT_W-1:0]       edge_cnt_q;
  logic [CNT_W-1:0]       edge_cnt_nxt;
  logic [CNT_W-1:0]       edge_sum;
  logic [CNT_W-1:0]       loss_q;
  logic [CNT_W-1:0]       loss_nxt;
  logic [CNT_W-1:0]       freq_nxt;
  logic [FAULT_CNT_W-1:0] fault_cnt_nxt;
  logic                   edge_pulse;
  ctrl_out_t              outs_nxt;

  gte2_refclk_sync u_sync (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .refclk_tgl (refclk_tgl),
    .edge_pulse (edge_pulse)
  );

  // Window count including the current cycle's pulse, saturating.
  assign edge_sum = (edge_cnt_q == CNT_MAX) ? edge_cnt_q
                                            : edge_cnt_q + {{(CNT_W-1){1'b0}}, edge_pulse};

  always_comb begin
    state_nxt     = state_q;
    timer_nxt     = timer_q;
    edge_cnt_nxt  = edge_cnt_q;
    loss_nxt      = loss_q;
    freq_nxt      = freq_count;
    fault_cnt_nxt = fault_cnt;

    if (!enable) begin
      state_nxt    = ST_OFF;
      timer_nxt    = '0;
      edge_cnt_nxt = '0;
      loss_nxt     = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_nxt = ST_SETTLE;
          timer_nxt = SETTLE_LOAD;
        end
        ST_SETTLE, ST_FAULT: begin
          if (timer_q == '0) begin
            state_nxt    = ST_MEASURE;
            timer_nxt    = WINDOW_LOAD;
            edge_cnt_nxt = '0;
          end else begin
            timer_nxt = timer_q - CNT_ONE;
          end
        end
        ST_MEASURE: begin
          edge_cnt_nxt = edge_sum;
          if (timer_q == '0) begin
            freq_nxt = edge_sum;
            if (edge_sum >= MIN_C && edge_sum <= MAX_C) begin
              state_nxt = ST_READY;
              loss_nxt  = '0;
            end else begin
              state_nxt = ST_FAULT;
              timer_nxt = SETTLE_LOAD;
            end
          end else begin
            timer_nxt = timer_q - CNT_ONE;
          end
        end
        ST_READY: begin
          // A pulse on the threshold cycle wins over the loss verdict.
          if (edge_pulse) begin
            loss_nxt = '0;
          end else if (loss_q == LOSS_C) begin
            state_nxt = ST_FAULT;
            timer_nxt = SETTLE_LOAD;
            loss_nxt  = '0;
          end else begin
            loss_nxt = loss_q + CNT_ONE;
          end
        end
        default: state_nxt = ST_OFF;
      endcase
    end

    if (state_nxt == ST_FAULT && state_q != ST_FAULT && fault_cnt != FCNT_MAX)
      fault_cnt_nxt = fault_cnt + FCNT_ONE;
  end

  assign outs_nxt = decode_outputs(state_nxt);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_OFF;
      timer_q      <= '0;
      edge_cnt_q   <= '0;
      loss_q       <= '0;
      freq_count   <= '0;
      fault_cnt    <= '0;
      ceb          <= 1'b1;
      gt_reset     <= 1'b1;
      refclk_ready <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      timer_q      <= timer_nxt;
      edge_cnt_q   <= edge_cnt_nxt;
      loss_q       <= loss_nxt;
      freq_count   <= freq_nxt;
      fault_cnt    <= fault_cnt_nxt;
      ceb          <= outs_nxt.ceb;
      gt_reset     <= outs_nxt.gt_reset;
      refclk_ready <= outs_nxt.refclk_ready;
      fault        <= outs_nxt.fault;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_gte2_refclk_ctrl.sv
// Scoreboard bench for gte2_refclk_ctrl: expected state transitions are queued
// by the stimulus and checked by a monitor whenever the DUT changes state.
module tb_gte2_refclk_ctrl;

  localparam int S    = 16;
  localparam int W    = 64;
  localparam int MINE = 10;
  localparam int MAXE = 20;
  localparam int L    = 16;
  localparam int CW   = 16;

  localparam logic [2:0] OFF = 3'd0, SETTLE = 3'd1, MEASURE = 3'd2, READY = 3'd3, FAULT = 3'd4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          enable;
  logic          refclk_tgl;
  logic          ceb;
  logic          gt_reset;
  logic          refclk_ready;
  logic          fault;
  logic [CW-1:0] freq_count;
  logic [7:0]    fault_cnt;
  logic [2:0]    state;

  gte2_refclk_ctrl #(
    .SETTLE_CYCLES (S),
    .WINDOW_CYCLES (W),
    .MIN_EDGES     (MINE),
    .MAX_EDGES     (MAXE),
    .LOSS_CYCLES   (L),
    .CNT_W         (CW)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .enable       (enable),
    .refclk_tgl   (refclk_tgl),
    .ceb          (ceb),
    .gt_reset     (gt_reset),
    .refclk_ready (refclk_ready),
    .fault        (fault),
    .freq_count   (freq_count),
    .fault_cnt    (fault_cnt),
    .state        (state)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] st;
    int cyc_lo;
    int cyc_hi;
    int f_lo;
    int f_hi;
    int fc;
  } exp_t;

  exp_t exp_q[$];
  bit   sched[int];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: fault entries since reset and last window's count range.
  int m_fc  = 0;
  int m_flo = 0;
  int m_fhi = 0;

  task automatic chk(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d..%0d (t=%0t cyc=%0d)", name, act, lo, hi, $time, cyc);
    end
  endtask

  // {ceb, gt_reset, refclk_ready, fault} required in each state.
  function automatic int exp_outs(input logic [2:0] st);
    case (st)
      OFF:     return 4'b1100;
      READY:   return 4'b0010;
      FAULT:   return 4'b0101;
      default: return 4'b0100;
    endcase
  endfunction

  task automatic push(input logic [2:0] st, input int clo, input int chi,
                      input int flo, input int fhi, input int fc);
    exp_t e;
    e.st = st; e.cyc_lo = clo; e.cyc_hi = chi; e.f_lo = flo; e.f_hi = fhi; e.fc = fc;
    exp_q.push_back(e);
  endtask

  // Toggles occurring at cycle c are seen 3 or 4 edges later; count both ways.
  function automatic int cnt_lat(input int m, input int lat);
    int n = 0;
    for (int c = m + 1 - lat; c <= m + W - lat; c++)
      if (sched.exists(c)) n++;
    return n;
  endfunction

  task automatic model_window(input int m, output bit pass);
    int a;
    int b;
    a = cnt_lat(m, 3);
    b = cnt_lat(m, 4);
    m_flo = (a < b) ? a : b;
    m_fhi = (a < b) ? b : a;
    pass  = (m_flo >= MINE) && (m_fhi <= MAXE);
  endtask

  // Queue MEASURE at m and the verdict at m+W; returns the verdict.
  task automatic expect_window(input int m, output bit pass);
    push(MEASURE, m, m, m_flo, m_fhi, m_fc);
    model_window(m, pass);
    if (pass) begin
      push(READY, m + W, m + W, m_flo, m_fhi, m_fc);
    end else begin
      if (m_fc < 255) m_fc++;
      push(FAULT, m + W, m + W, m_flo, m_fhi, m_fc);
    end
  endtask

  task automatic add_periodic(input int a, input int b, input int p, output int last);
    last = a;
    for (int c = a; c <= b; c += p) begin
      sched[c] = 1'b1;
      last = c;
    end
  endtask

  task automatic summary_and_finish();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge aclk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d transitions still pending after %0d cycles, want 0", exp_q.size(), budget);
      summary_and_finish();
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge aclk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"},        int'(state),        0, 0);
    chk({tag, "_ceb"},          int'(ceb),          1, 1);
    chk({tag, "_gt_reset"},     int'(gt_reset),     1, 1);
    chk({tag, "_refclk_ready"}, int'(refclk_ready), 0, 0);
    chk({tag, "_fault"},        int'(fault),        0, 0);
    chk({tag, "_freq_count"},   int'(freq_count),   0, 0);
    chk({tag, "_fault_cnt"},    int'(fault_cnt),    0, 0);
  endtask

  always @(negedge aclk) begin
    if (sched.exists(cyc)) refclk_tgl = ~refclk_tgl;
  end

  logic [2:0] prev_st = 3'd0;
  exp_t       mon_e;
  always @(negedge aclk) begin
    if (state != prev_st) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_transition: got state %0d (from %0d) at cyc %0d, want no change",
                 state, prev_st, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("state",      int'(state), int'(mon_e.st), int'(mon_e.st));
        chk($sformatf("entry_cycle_st%0d", mon_e.st), cyc, mon_e.cyc_lo, mon_e.cyc_hi);
        chk("freq_count", int'(freq_count), mon_e.f_lo, mon_e.f_hi);
        chk("fault_cnt",  int'(fault_cnt), mon_e.fc, mon_e.fc);
        chk($sformatf("outputs_st%0d", mon_e.st), int'({ceb, gt_reset, refclk_ready, fault}),
            exp_outs(mon_e.st), exp_outs(mon_e.st));
      end
      prev_st = state;
    end
  end

  int c0, c1, m, last, d, p, r, tmp, j;
  bit pass;
  int ns[4];

  initial begin
    aresetn    = 1'b1;
    enable     = 1'b0;
    refclk_tgl = 1'b0;
    #1 aresetn = 1'b0;
    #1 chk_reset("por");
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Good clock (toggle every 4), then the clock stops while READY.
    c0 = cyc;
    enable = 1'b1;
    m = c0 + 1 + S;
    add_periodic(c0 + 2, m + W + 20 + int'($urandom_range(0, 7)), 4, last);
    push(SETTLE, c0 + 1, c0 + 1, m_flo, m_fhi, m_fc);
    expect_window(m, pass);
    if (pass) begin
      if (m_fc < 255) m_fc++;
      push(FAULT, last + 18, last + 20, m_flo, m_fhi, m_fc);
    end
    drain(S + W + 100);
    @(negedge aclk);
    c1 = cyc;
    enable = 1'b0;
    push(OFF, c1 + 1, c1 + 1, m_flo, m_fhi, m_fc);
    drain(10);

    // Exact edge bursts across both pass-band boundaries, in random order.
    ns = '{9, 10, 20, 21};
    for (int i = 3; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = ns[i]; ns[i] = ns[j]; ns[j] = tmp;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      c0 = cyc;
      enable = 1'b1;
      m = c0 + 1 + S;
      r = int'($urandom_range(5, 10));
      for (int i = 0; i < ns[k]; i++) sched[m + r + 2 * i] = 1'b1;
      push(SETTLE, c0 + 1, c0 + 1, m_flo, m_fhi, m_fc);
      expect_window(m, pass);
      wait_cyc(m + W + int'($urandom_range(1, 8)));
      c1 = cyc;
      enable = 1'b0;
      push(OFF, c1 + 1, c1 + 1, m_flo, m_fhi, m_fc);
      drain(S + W + 40);
    end

    // enable falls mid-window, then exactly on the window's last cycle.
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      c0 = cyc;
      enable = 1'b1;
      m = c0 + 1 + S;
      add_periodic(c0 + 2, m + W + 10, 4, last);
      push(SETTLE, c0 + 1, c0 + 1, m_flo, m_fhi, m_fc);
      push(MEASURE, m, m, m_flo, m_fhi, m_fc);
      d = (k == 0) ? m + int'($urandom_range(0, W - 3)) : m + W - 1;
      wait_cyc(d);
      enable = 1'b0;
      push(OFF, d + 1, d + 1, m_flo, m_fhi, m_fc);
      for (int c = d + 1; c <= last; c++) sched.delete(c);
      drain(S + W + 40);
    end

    // Clock far out of band: 300 FAULT/MEASURE retries, fault_cnt saturates.
    @(negedge aclk);
    c0 = cyc;
    enable = 1'b1;
    p = ($urandom_range(0, 1) != 0) ? 2 : 8;
    m = c0 + 1 + S;
    add_periodic(c0 + 2, m + 300 * (W + S) + 10, p, last);
    push(SETTLE, c0 + 1, c0 + 1, m_flo, m_fhi, m_fc);
    for (int k = 0; k < 300; k++) begin
      expect_window(m, pass);
      if (pass) break;
      m = m + W + S;
    end
    wait_cyc(m - S + 2);
    c1 = cyc;
    enable = 1'b0;
    push(OFF, c1 + 1, c1 + 1, m_flo, m_fhi, m_fc);
    for (int c = c1 + 1; c <= last; c++) sched.delete(c);
    drain(300 * (W + S) + 100);
    chk("fault_cnt_saturated", int'(fault_cnt), 255, 255);

    // Reach READY with a toggle every 5 cycles, then assert reset asynchronously.
    @(negedge aclk);
    c0 = cyc;
    enable = 1'b1;
    m = c0 + 1 + S;
    add_periodic(c0 + 2, m + W + 60, 5, last);
    push(SETTLE, c0 + 1, c0 + 1, m_flo, m_fhi, m_fc);
    expect_window(m, pass);
    drain(S + W + 20);
    wait_cyc(cyc + int'($urandom_range(2, 10)));
    push(OFF, cyc + 1, cyc + 1, 0, 0, 0);
    m_fc  = 0;
    m_flo = 0;
    m_fhi = 0;
    #(int'($urandom_range(1, 3)));
    aresetn = 1'b0;
    #1 chk_reset("async_reset");
    sched.delete();
    @(negedge aclk);
    enable = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    drain(10);
    repeat (5) @(negedge aclk);
    chk("idle_state_after_reset", int'(state), 0, 0);

    summary_and_finish();
  end

endmodule
